// File: rtl/debug_unit.sv
// Host-side debug controller: decodes UART commands, loads imem, runs/steps the pipeline, dumps state over UART.
// Latency: one imem write 1 cycle after the 4th byte of a word; dump sends 1 byte per transmitter handshake.
// Backpressure: a new byte is started only after i_tx_done; RX bytes outside IDLE/LOAD are dropped.
//
// Ports:
//   i_clk, i_reset (async, active-high)
//   i_rx_data/i_rx_done           : byte stream from the UART receiver
//   o_tx_data/o_tx_start/i_tx_done: byte stream to the UART transmitter
//   o_stop                        : 1 freezes the pipeline
//   o_write_instruction_mem, o_instruction_mem_addr/data : imem write port
//   o_r_addr_registers/o_r_addr_data_mem, i_r_data_*     : debug read ports (combinational data)
//   i_IF_ID/i_ID_EX/i_EX_MEM/i_MEM_WB                    : pipeline latch snapshots
//   i_end                                               : pipeline reached HALT
// Optional feature: define DEBUG_LATCH_DUMP_EN to append the four pipeline latches after dmem.
module debug_unit #(
    parameter int DATA_WORDS   = 32,
    parameter int NB_DMEM_ADDR = 5,
    parameter int IMEM_BYTES   = 256,
    parameter int DRAIN_CYCLES = 3,
    parameter int NB_IF_ID     = 64,
    parameter int NB_ID_EX     = 139,
    parameter int NB_EX_MEM    = 76,
    parameter int NB_MEM_WB    = 71
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [7:0]              i_rx_data,
    input  logic                    i_rx_done,
    output logic [7:0]              o_tx_data,
    output logic                    o_tx_start,
    input  logic                    i_tx_done,
    output logic                    o_stop,
    output logic                    o_write_instruction_mem,
    output logic [31:0]             o_instruction_mem_addr,
    output logic [31:0]             o_instruction_mem_data,
    output logic [4:0]              o_r_addr_registers,
    output logic [NB_DMEM_ADDR-1:0] o_r_addr_data_mem,
    input  logic [31:0]             i_r_data_registers,
    input  logic [31:0]             i_r_data_data_mem,
    input  logic [NB_IF_ID-1:0]     i_IF_ID,
    input  logic [NB_ID_EX-1:0]     i_ID_EX,
    input  logic [NB_EX_MEM-1:0]    i_EX_MEM,
    input  logic [NB_MEM_WB-1:0]    i_MEM_WB,
    input  logic                    i_end
);

    // Dump layout in byte indices: regs [0,128), dmem [128,DMEM_END), then optional latches.
    localparam logic [8:0]  REG_END    = 9'd128;
    localparam logic [8:0]  DMEM_END   = 9'(128 + 4 * DATA_WORDS);
    localparam logic [31:0] LAST_ADDR  = 32'(IMEM_BYTES - 4);
    localparam logic [7:0]  DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

`ifdef DEBUG_LATCH_DUMP_EN
    localparam int B_IF_ID  = (NB_IF_ID  + 7) / 8;
    localparam int B_ID_EX  = (NB_ID_EX  + 7) / 8;
    localparam int B_EX_MEM = (NB_EX_MEM + 7) / 8;
    localparam int B_MEM_WB = (NB_MEM_WB + 7) / 8;
    localparam int MAX_AB   = (B_IF_ID  > B_ID_EX)  ? B_IF_ID  : B_ID_EX;
    localparam int MAX_CD   = (B_EX_MEM > B_MEM_WB) ? B_EX_MEM : B_MEM_WB;
    localparam int MAX_B    = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int SH_W     = (MAX_B > 4) ? 8 * MAX_B : 32;
    localparam logic [8:0] L_ID_EX  = DMEM_END + 9'(B_IF_ID);
    localparam logic [8:0] L_EX_MEM = L_ID_EX  + 9'(B_ID_EX);
    localparam logic [8:0] TOTAL    = L_EX_MEM + 9'(B_EX_MEM + B_MEM_WB);
`else
    localparam int         SH_W  = 32;
    localparam logic [8:0] TOTAL = DMEM_END;
`endif

    typedef enum logic [3:0] {
        IDLE, LOAD_BYTE, LOAD_WRITE, LOAD_ACK, RUN, DRAIN, STEP,
        DUMP_ADDR, DUMP_SEND, DUMP_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     word_q, word_d;
    logic [1:0]      load_cnt_q, load_cnt_d;
    logic            ack_sent_q, ack_sent_d;
    logic [7:0]      drain_q, drain_d;
    logic [8:0]      byte_cnt_q, byte_cnt_d;
    logic [7:0]      item_q, item_d;     // bytes left in the item held in sh_q
    logic [SH_W-1:0] sh_q, sh_d;         // current item, MSB-aligned; top byte is on the wire

    logic            in_regs, in_dmem;
    logic [8:0]      dm_word;

    assign in_regs = (byte_cnt_q < REG_END);
    assign in_dmem = (byte_cnt_q >= REG_END) && (byte_cnt_q < DMEM_END);
    assign dm_word = (byte_cnt_q - REG_END) >> 2;

    // Read addresses follow the byte counter so data is valid while in DUMP_ADDR.
    assign o_r_addr_registers = in_regs ? byte_cnt_q[6:2] : 5'd0;
    assign o_r_addr_data_mem  = in_dmem ? dm_word[NB_DMEM_ADDR-1:0] : '0;

    assign o_stop                  = !((state_q == RUN) || (state_q == DRAIN) || (state_q == STEP));
    assign o_write_instruction_mem = (state_q == LOAD_WRITE);
    assign o_instruction_mem_addr  = addr_q;
    assign o_instruction_mem_data  = word_q;
    assign o_tx_start = (state_q == DUMP_SEND) || ((state_q == LOAD_ACK) && !ack_sent_q);
    assign o_tx_data  = (state_q == LOAD_ACK) ? 8'h4B : sh_q[SH_W-1 -: 8];

`ifndef DEBUG_LATCH_DUMP_EN
    logic unused_latches;
    assign unused_latches = ^{i_IF_ID, i_ID_EX, i_EX_MEM, i_MEM_WB};
`endif
    logic unused_dm_word;
    assign unused_dm_word = ^dm_word;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        word_d     = word_q;
        load_cnt_d = load_cnt_q;
        ack_sent_d = ack_sent_q;
        drain_d    = drain_q;
        byte_cnt_d = byte_cnt_q;
        item_d     = item_q;
        sh_d       = sh_q;

        case (state_q)
            IDLE: begin
                byte_cnt_d = '0;
                if (i_rx_done) begin
                    case (i_rx_data)
                        8'h4C: begin
                            state_d    = LOAD_BYTE;
                            addr_d     = '0;
                            load_cnt_d = '0;
                        end
                        8'h53: state_d = STEP;
                        // Already halted: nothing to run, go straight to the dump.
                        8'h43: state_d = i_end ? DUMP_ADDR : RUN;
                        default: ;
                    endcase
                end
            end

            LOAD_BYTE: begin
                if (i_rx_done) begin
                    word_d     = {word_q[23:0], i_rx_data};
                    load_cnt_d = load_cnt_q + 2'd1;
                    if (load_cnt_q == 2'd3) state_d = LOAD_WRITE;
                end
            end

            LOAD_WRITE: begin
                // HALT word or last imem slot ends the load; the address never wraps.
                if ((word_q == 32'hFFFF_FFFF) || (addr_q == LAST_ADDR)) begin
                    state_d    = LOAD_ACK;
                    ack_sent_d = 1'b0;
                end else begin
                    addr_d  = addr_q + 32'd4;
                    state_d = LOAD_BYTE;
                end
            end

            LOAD_ACK: begin
                if (!ack_sent_q)    ack_sent_d = 1'b1;
                else if (i_tx_done) state_d    = IDLE;
            end

            RUN: begin
                if (i_end) begin
                    drain_d = '0;
                    state_d = (DRAIN_CYCLES == 0) ? DUMP_ADDR : DRAIN;
                end
            end

            DRAIN: begin
                if (drain_q == DRAIN_LAST) state_d = DUMP_ADDR;
                else                       drain_d = drain_q + 8'd1;
            end

            STEP: state_d = DUMP_ADDR;

            DUMP_ADDR: begin
                item_d  = 8'd4;
                state_d = DUMP_SEND;
                if (in_regs)
                    sh_d = SH_W'(i_r_data_registers) << (SH_W - 32);
                else if (in_dmem)
                    sh_d = SH_W'(i_r_data_data_mem) << (SH_W - 32);
`ifdef DEBUG_LATCH_DUMP_EN
                // Zero-extend then left-align so the padding lands at the MSB end.
                else if (byte_cnt_q == DMEM_END) begin
                    sh_d   = SH_W'(i_IF_ID) << (SH_W - 8 * B_IF_ID);
                    item_d = 8'(B_IF_ID);
                end else if (byte_cnt_q == L_ID_EX) begin
                    sh_d   = SH_W'(i_ID_EX) << (SH_W - 8 * B_ID_EX);
                    item_d = 8'(B_ID_EX);
                end else if (byte_cnt_q == L_EX_MEM) begin
                    sh_d   = SH_W'(i_EX_MEM) << (SH_W - 8 * B_EX_MEM);
                    item_d = 8'(B_EX_MEM);
                end else begin
                    sh_d   = SH_W'(i_MEM_WB) << (SH_W - 8 * B_MEM_WB);
                    item_d = 8'(B_MEM_WB);
                end
`endif
            end

            DUMP_SEND: state_d = DUMP_WAIT;

            DUMP_WAIT: begin
                if (i_tx_done) begin
                    byte_cnt_d = byte_cnt_q + 9'd1;
                    item_d     = item_q - 8'd1;
                    sh_d       = sh_q << 8;
                    if (byte_cnt_q == TOTAL - 9'd1) begin
                        state_d    = IDLE;
                        byte_cnt_d = '0;
                    end else if (item_q == 8'd1) begin
                        state_d = DUMP_ADDR;
                    end else begin
                        state_d = DUMP_SEND;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            word_q     <= '0;
            load_cnt_q <= '0;
            ack_sent_q <= 1'b0;
            drain_q    <= '0;
            byte_cnt_q <= '0;
            item_q     <= '0;
            sh_q       <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            load_cnt_q <= load_cnt_d;
            ack_sent_q <= ack_sent_d;
            drain_q    <= drain_d;
            byte_cnt_q <= byte_cnt_d;
            item_q     <= item_d;
            sh_q       <= sh_d;
        end
    end

endmodule

// File: tb/tb_debug_unit.sv
// Directed bench for debug_unit: load, step, continue/drain, reset mid-dump, ignored bytes.
// A small transmitter model answers each start with a delayed done and records sent bytes.
// Register/dmem read data come from a combinational model of the pipeline state.
module tb_debug_unit;

`ifdef DEBUG_LATCH_DUMP_EN
    localparam int TOTAL = 301;
`else
    localparam int TOTAL = 256;
`endif

    logic         i_clk = 1'b0;
    logic         i_reset;
    logic [7:0]   i_rx_data;
    logic         i_rx_done;
    logic [7:0]   o_tx_data;
    logic         o_tx_start;
    logic         i_tx_done;
    logic         o_stop;
    logic         o_write_instruction_mem;
    logic [31:0]  o_instruction_mem_addr;
    logic [31:0]  o_instruction_mem_data;
    logic [4:0]   o_r_addr_registers;
    logic [4:0]   o_r_addr_data_mem;
    logic [31:0]  i_r_data_registers;
    logic [31:0]  i_r_data_data_mem;
    logic [63:0]  i_IF_ID;
    logic [138:0] i_ID_EX;
    logic [75:0]  i_EX_MEM;
    logic [70:0]  i_MEM_WB;
    logic         i_end;

    always #5 i_clk = ~i_clk;

    debug_unit dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
        .o_stop(o_stop),
        .o_write_instruction_mem(o_write_instruction_mem),
        .o_instruction_mem_addr(o_instruction_mem_addr),
        .o_instruction_mem_data(o_instruction_mem_data),
        .o_r_addr_registers(o_r_addr_registers), .o_r_addr_data_mem(o_r_addr_data_mem),
        .i_r_data_registers(i_r_data_registers), .i_r_data_data_mem(i_r_data_data_mem),
        .i_IF_ID(i_IF_ID), .i_ID_EX(i_ID_EX), .i_EX_MEM(i_EX_MEM), .i_MEM_WB(i_MEM_WB),
        .i_end(i_end)
    );

    // Pipeline state model: reg n = n*0x01010101, dmem k = 0xA0000000+k.
    assign i_r_data_registers = {4{3'b000, o_r_addr_registers}};
    assign i_r_data_data_mem  = 32'hA000_0000 + {27'd0, o_r_addr_data_mem};
    assign i_IF_ID  = {32'h0050_0093, 32'd8};
    assign i_ID_EX  = '0;
    assign i_EX_MEM = '0;
    assign i_MEM_WB = '0;

    int checks = 0;
    int errors = 0;

    logic [7:0]  tx_q[$];
    int          tx_delay = 2;
    int          double_start = 0;
    int          unstable = 0;
    int          wr_cnt = 0;
    logic [31:0] wr_addr [0:127];
    logic [31:0] wr_data [0:127];
    int          stop_low = 0;

    // Write / stop monitor.
    initial begin
        forever begin
            @(negedge i_clk);
            if (o_write_instruction_mem) begin
                if (wr_cnt < 128) begin
                    wr_addr[wr_cnt] = o_instruction_mem_addr;
                    wr_data[wr_cnt] = o_instruction_mem_data;
                end
                wr_cnt++;
            end
            if (!o_stop) stop_low++;
        end
    end

    // Transmitter model: done pulse tx_delay+1 cycles after each start.
    initial begin : tx_model
        int         cnt;
        bit         busy;
        logic [7:0] cur;
        cnt = 0; busy = 0; cur = 8'h00;
        i_tx_done = 1'b0;
        forever begin
            @(negedge i_clk);
            i_tx_done = 1'b0;
            if (i_reset) begin
                busy = 0;
            end else if (busy) begin
                if (o_tx_start) double_start++;
                if (o_tx_data !== cur) unstable++;
                if (cnt == 0) begin
                    i_tx_done = 1'b1;
                    busy = 0;
                end else begin
                    cnt--;
                end
            end else if (o_tx_start) begin
                busy = 1;
                cur = o_tx_data;
                tx_q.push_back(cur);
                cnt = tx_delay;
            end
        end
    end

    function automatic logic [7:0] exp_byte(input int i);
        logic [31:0] w;
        logic [63:0] ifid;
        int wi;
        wi = i / 4;
        ifid = {32'h0050_0093, 32'd8};
        if (wi < 32)      w = {4{wi[7:0]}};
        else if (wi < 64) w = 32'hA000_0000 + 32'(wi - 32);
        else begin
            if (i < 264) return ifid[63 - 8 * (i - 256) -: 8];
            return 8'h00;
        end
        return w[31 - 8 * (i % 4) -: 8];
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(posedge i_clk); #1;
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(posedge i_clk); #1;
        i_rx_done = 1'b0;
    endtask

    task automatic wait_bytes(input int target, input int budget, output bit ok);
        ok = 0;
        for (int c = 0; c < budget; c++) begin
            @(posedge i_clk);
            if (tx_q.size() >= target) begin
                ok = 1;
                break;
            end
        end
        repeat (10) @(posedge i_clk);
    endtask

    task automatic test_reset;
        i_reset = 1'b1;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        checks++; if (o_stop !== 1'b1) begin errors++; $display("FAIL reset_stop got %b want 1", o_stop); end
        checks++; if (o_tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %b want 0", o_tx_start); end
        checks++; if (o_tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", o_tx_data); end
        checks++; if (o_write_instruction_mem !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", o_write_instruction_mem); end
        checks++; if ({o_instruction_mem_addr, o_instruction_mem_data} !== 64'd0) begin
            errors++; $display("FAIL reset_imem got %h %h want 0 0", o_instruction_mem_addr, o_instruction_mem_data); end
        checks++; if ({o_r_addr_registers, o_r_addr_data_mem} !== 10'd0) begin
            errors++; $display("FAIL reset_raddr got %h %h want 0 0", o_r_addr_registers, o_r_addr_data_mem); end
        @(posedge i_clk); #1;
        i_reset = 1'b0;
    endtask

    task automatic test_load;
        logic [31:0] prog [4];
        int bw, bq;
        bit ok;
        prog = '{32'h0050_0093, 32'h0010_2023, 32'h0000_2103, 32'hFFFF_FFFF};
        tx_delay = 100;
        bw = wr_cnt; bq = tx_q.size();
        send_byte(8'h4C);
        for (int k = 0; k < 4; k++)
            for (int b = 3; b >= 0; b--) send_byte(prog[k][8*b +: 8]);
        wait_bytes(bq + 1, 300, ok);
        repeat (110) @(posedge i_clk);
        checks++; if (wr_cnt - bw !== 4) begin errors++; $display("FAIL load_writes got %0d want 4", wr_cnt - bw); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (wr_addr[bw + k] !== 32'(4 * k)) begin
                errors++; $display("FAIL load_addr%0d got %h want %h", k, wr_addr[bw + k], 4 * k); end
            checks++; if (wr_data[bw + k] !== prog[k]) begin
                errors++; $display("FAIL load_data%0d got %h want %h", k, wr_data[bw + k], prog[k]); end
        end
        checks++; if (!ok || tx_q.size() - bq !== 1) begin
            errors++; $display("FAIL load_ack_count got %0d want 1", tx_q.size() - bq); end
        else begin
            checks++; if (tx_q[bq] !== 8'h4B) begin errors++; $display("FAIL load_ack_byte got %h want 4b", tx_q[bq]); end
        end
        checks++; if (double_start !== 0) begin errors++; $display("FAIL slow_done_double_start got %0d want 0", double_start); end
        tx_delay = 2;
    endtask

    task automatic test_load_limit;
        int bw, bq;
        bit ok;
        bw = wr_cnt; bq = tx_q.size();
        send_byte(8'h4C);
        for (int k = 0; k < 64; k++) begin
            send_byte(8'h12); send_byte(8'h34); send_byte(8'h00); send_byte(8'(k));
        end
        wait_bytes(bq + 1, 100, ok);
        checks++; if (wr_cnt - bw !== 64) begin errors++; $display("FAIL limit_writes got %0d want 64", wr_cnt - bw); end
        checks++; if (wr_addr[bw + 63] !== 32'd252 || wr_data[bw + 63] !== 32'h1234_003F) begin
            errors++; $display("FAIL limit_last got %h %h want 000000fc 1234003f", wr_addr[bw + 63], wr_data[bw + 63]); end
        checks++; if (!ok || tx_q[bq] !== 8'h4B) begin errors++; $display("FAIL limit_ack got %0d bytes want 1 (4b)", tx_q.size() - bq); end
    endtask

    task automatic test_step;
        int bs, bq, bad;
        bit ok;
        bs = stop_low; bq = tx_q.size(); bad = 0;
        send_byte(8'h53);
        wait_bytes(bq + TOTAL, 4000, ok);
        checks++; if (stop_low - bs !== 1) begin errors++; $display("FAIL step_stop_low got %0d want 1", stop_low - bs); end
        checks++; if (!ok || tx_q.size() - bq !== TOTAL) begin
            errors++; $display("FAIL step_len got %0d want %0d", tx_q.size() - bq, TOTAL); end
        for (int i = 0; i < TOTAL && bq + i < tx_q.size(); i++) if (tx_q[bq + i] !== exp_byte(i)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL step_bytes got %0d bad bytes want 0", bad); end
        checks++; if (o_stop !== 1'b1) begin errors++; $display("FAIL step_stop_after got %b want 1", o_stop); end
    endtask

    task automatic test_run;
        int bs, bq, bad;
        bit ok;
        bs = stop_low; bq = tx_q.size(); bad = 0;
        send_byte(8'h43);
        repeat (9) @(posedge i_clk);
        #1 i_end = 1'b1;
        wait_bytes(bq + TOTAL, 4000, ok);
        i_end = 1'b0;
        checks++; if (stop_low - bs !== 13) begin errors++; $display("FAIL run_stop_low got %0d want 13", stop_low - bs); end
        checks++; if (!ok || tx_q.size() - bq !== TOTAL) begin
            errors++; $display("FAIL run_len got %0d want %0d", tx_q.size() - bq, TOTAL); end
        for (int i = 0; i < TOTAL && bq + i < tx_q.size(); i++) if (tx_q[bq + i] !== exp_byte(i)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL run_bytes got %0d bad bytes want 0", bad); end
    endtask

    task automatic test_end_high;
        int bs, bq;
        bit ok;
        bs = stop_low; bq = tx_q.size();
        i_end = 1'b1;
        send_byte(8'h43);
        wait_bytes(bq + TOTAL, 4000, ok);
        i_end = 1'b0;
        checks++; if (stop_low - bs !== 0) begin errors++; $display("FAIL endhigh_stop_low got %0d want 0", stop_low - bs); end
        checks++; if (!ok || tx_q.size() - bq !== TOTAL) begin
            errors++; $display("FAIL endhigh_len got %0d want %0d", tx_q.size() - bq, TOTAL); end
    endtask

    task automatic test_reset_mid;
        int bq, bad;
        bit ok;
        bq = tx_q.size(); bad = 0;
        send_byte(8'h53);
        wait_bytes(bq + 50, 1000, ok);
        @(negedge i_clk); #1 i_reset = 1'b1;
        #2;
        checks++; if (o_stop !== 1'b1 || o_tx_start !== 1'b0) begin
            errors++; $display("FAIL midreset_out got stop=%b start=%b want 1 0", o_stop, o_tx_start); end
        @(posedge i_clk); #1 i_reset = 1'b0;
        bq = tx_q.size();
        repeat (20) @(posedge i_clk);
        checks++; if (tx_q.size() !== bq) begin errors++; $display("FAIL midreset_quiet got %0d bytes want 0", tx_q.size() - bq); end
        send_byte(8'h53);
        wait_bytes(bq + TOTAL, 4000, ok);
        checks++; if (!ok || tx_q.size() - bq !== TOTAL) begin
            errors++; $display("FAIL midreset_len got %0d want %0d", tx_q.size() - bq, TOTAL); end
        for (int i = 0; i < TOTAL && bq + i < tx_q.size(); i++) if (tx_q[bq + i] !== exp_byte(i)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL midreset_bytes got %0d bad bytes want 0", bad); end
    endtask

    task automatic test_ignore;
        int bw, bq, bad;
        bit ok;
        bw = wr_cnt; bq = tx_q.size(); bad = 0;
        send_byte(8'h58);
        repeat (20) @(posedge i_clk);
        checks++; if (tx_q.size() !== bq || wr_cnt !== bw || o_stop !== 1'b1) begin
            errors++; $display("FAIL ignore_x got tx=%0d wr=%0d stop=%b want 0 0 1", tx_q.size() - bq, wr_cnt - bw, o_stop); end
        send_byte(8'h53);
        wait_bytes(bq + 10, 1000, ok);
        send_byte(8'h4C);
        for (int b = 0; b < 4; b++) send_byte(8'h00);
        wait_bytes(bq + TOTAL, 4000, ok);
        checks++; if (wr_cnt !== bw) begin errors++; $display("FAIL ignore_l_writes got %0d want 0", wr_cnt - bw); end
        checks++; if (!ok || tx_q.size() - bq !== TOTAL) begin
            errors++; $display("FAIL ignore_len got %0d want %0d", tx_q.size() - bq, TOTAL); end
        for (int i = 0; i < TOTAL && bq + i < tx_q.size(); i++) if (tx_q[bq + i] !== exp_byte(i)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL ignore_bytes got %0d bad bytes want 0", bad); end
        checks++; if (double_start !== 0 || unstable !== 0) begin
            errors++; $display("FAIL tx_protocol got double=%0d unstable=%0d want 0 0", double_start, unstable); end
    endtask

    initial begin
        i_reset = 1'b1;
        i_rx_data = 8'h00;
        i_rx_done = 1'b0;
        i_end = 1'b0;
        test_reset;
        test_load;
        test_load_limit;
        test_step;
        test_run;
        test_end_high;
        test_reset_mid;
        test_ignore;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
